// File: rtl/hard_act_pkg.sv
// Shared mode encodings and fixed-point constants for the hard activation pipeline.
// Constants are functions of the fraction width so any FRAC_BITS instance derives its own.
package hard_act_pkg;

  typedef enum logic [1:0] {
    HA_HSIG   = 2'd0,
    HA_HSWISH = 2'd1,
    HA_RELU   = 2'd2,
    HA_BYPASS = 2'd3
  } ha_mode_e;

  localparam int HA_STAGES = 4;

  function automatic longint ha_one(input int frac);
    return longint'(1) << frac;
  endfunction

  function automatic longint ha_round_half(input int frac);
    return longint'(1) << (frac - 1);
  endfunction

  // p carries 2F fraction bits: add 0.5 of the sigmoid offset plus half an output LSB
  function automatic longint ha_sig_offset(input int frac);
    return (longint'(1) << (2 * frac - 1)) + ha_round_half(frac);
  endfunction

  // |x| >= 2.5 is where the hard sigmoid is fully saturated
  function automatic longint ha_sat_knee(input int frac);
    return longint'(5) << (frac - 1);
  endfunction

endpackage

// File: rtl/hard_act_lane.sv
// Four-stage piecewise-linear activation datapath for one lane.
// Every stage register advances together on adv_i; mode_i is the mode of the beat in stage 2.
module hard_act_lane
  import hard_act_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int FRAC_BITS  = 9,
  parameter int IN_WIDTH   = 25,
  parameter int SIG_SLOPE  = 102
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         adv_i,
  input  ha_mode_e                     mode_i,
  input  logic signed [IN_WIDTH-1:0]   x_i,
  output logic signed [DATA_WIDTH-1:0] y_o
);

  localparam int PW = IN_WIDTH + 8;
  localparam int SW = PW + 1;
  localparam int HW = FRAC_BITS + 2;
  localparam int QW = IN_WIDTH + FRAC_BITS + 2;

  localparam logic signed [IN_WIDTH-1:0] KNEE_HI = IN_WIDTH'(ha_sat_knee(FRAC_BITS));
  localparam logic signed [IN_WIDTH-1:0] KNEE_LO = IN_WIDTH'(-ha_sat_knee(FRAC_BITS));
  localparam logic signed [PW-1:0]       SLOPE   = PW'(SIG_SLOPE);
  localparam logic signed [SW-1:0]       SIG_OFF = SW'(ha_sig_offset(FRAC_BITS));
  localparam logic signed [SW-1:0]       H_ONE_S = SW'(ha_one(FRAC_BITS));
  localparam logic [HW-1:0]              H_ONE   = HW'(ha_one(FRAC_BITS));
  localparam logic signed [QW-1:0]       Q_RND   = QW'(ha_round_half(FRAC_BITS));
  localparam logic signed [QW-1:0]       Y_MAX   = QW'((longint'(1) << (DATA_WIDTH - 1)) - 1);
  localparam logic signed [QW-1:0]       Y_MIN   = QW'(-(longint'(1) << (DATA_WIDTH - 1)));

  logic signed [IN_WIDTH-1:0]   x1_q, x2_q;
  logic signed [PW-1:0]         p1_d, p1_q;
  logic                         hi1_d, hi1_q, lo1_d, lo1_q;
  logic signed [SW-1:0]         hsum, hshift;
  logic [HW-1:0]                h2_d, h2_q;
  logic signed [HW:0]           hs;
  logic signed [QW-1:0]         q3_d, q3_q;
  logic signed [QW-1:0]         rsum, rshift;
  logic signed [DATA_WIDTH-1:0] y4_d, y4_q;

  always_comb begin
    p1_d  = PW'(x_i) * SLOPE;
    hi1_d = (x_i >= KNEE_HI);
    lo1_d = (x_i <= KNEE_LO);
  end

  // Knee flags override the rounded line so the ends are exact regardless of rounding
  always_comb begin
    hsum   = SW'(p1_q) + SIG_OFF;
    hshift = hsum >>> FRAC_BITS;
    if (hi1_q) begin
      h2_d = H_ONE;
    end else if (lo1_q || hshift[SW-1]) begin
      h2_d = '0;
    end else if (hshift > H_ONE_S) begin
      h2_d = H_ONE;
    end else begin
      h2_d = hshift[HW-1:0];
    end
  end

  always_comb begin
    hs   = $signed({1'b0, h2_q});
    q3_d = '0;
    case (mode_i)
      HA_HSWISH: q3_d = QW'(x2_q) * QW'(hs);
      HA_HSIG:   q3_d = QW'(hs) <<< FRAC_BITS;
      HA_RELU:   q3_d = x2_q[IN_WIDTH-1] ? '0 : (QW'(x2_q) <<< FRAC_BITS);
      default:   q3_d = QW'(x2_q) <<< FRAC_BITS;
    endcase
  end

  always_comb begin
    rsum   = q3_q + Q_RND;
    rshift = rsum >>> FRAC_BITS;
    if (rshift > Y_MAX) begin
      y4_d = Y_MAX[DATA_WIDTH-1:0];
    end else if (rshift < Y_MIN) begin
      y4_d = Y_MIN[DATA_WIDTH-1:0];
    end else begin
      y4_d = rshift[DATA_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      x1_q  <= '0;
      p1_q  <= '0;
      hi1_q <= 1'b0;
      lo1_q <= 1'b0;
      x2_q  <= '0;
      h2_q  <= '0;
      q3_q  <= '0;
      y4_q  <= '0;
    end else if (adv_i) begin
      x1_q  <= x_i;
      p1_q  <= p1_d;
      hi1_q <= hi1_d;
      lo1_q <= lo1_d;
      x2_q  <= x1_q;
      h2_q  <= h2_d;
      q3_q  <= q3_d;
      y4_q  <= y4_d;
    end
  end

  assign y_o = y4_q;

endmodule

// File: rtl/hard_act_pipe.sv
// Multi-lane hard-sigmoid / hard-swish / ReLU / bypass pipeline with valid/ready flow control.
// The whole pipe advances as one block, so a stalled output freezes every stage behind it.
module hard_act_pipe
  import hard_act_pkg::*;
#(
  parameter int DATA_WIDTH = 14,
  parameter int FRAC_BITS  = 9,
  parameter int IN_WIDTH   = 25,
  parameter int LANES      = 4,
  parameter int SIG_SLOPE  = 102
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [LANES*IN_WIDTH-1:0]     in_data,
  input  logic [1:0]                    in_mode,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [LANES*DATA_WIDTH-1:0]   out_data,
  output logic [1:0]                    out_mode
);

  logic                 adv;
  logic [HA_STAGES-1:0] valid_d, valid_q;
  ha_mode_e             mode_d;
  ha_mode_e             mode_q [HA_STAGES];

  assign adv      = ~out_valid | out_ready;
  assign in_ready = adv;

  always_comb begin
    valid_d = {valid_q[HA_STAGES-2:0], in_valid};
    mode_d  = ha_mode_e'(in_mode);
  end

  // Valid bits shift even when empty, so bubbles travel with the beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
      for (int i = 0; i < HA_STAGES; i++) mode_q[i] <= HA_HSIG;
    end else if (adv) begin
      valid_q   <= valid_d;
      mode_q[0] <= mode_d;
      for (int i = 1; i < HA_STAGES; i++) mode_q[i] <= mode_q[i-1];
    end
  end

  assign out_valid = valid_q[HA_STAGES-1];
  assign out_mode  = mode_q[HA_STAGES-1];

  for (genvar g = 0; g < LANES; g++) begin : gLane
    hard_act_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .FRAC_BITS (FRAC_BITS),
      .IN_WIDTH  (IN_WIDTH),
      .SIG_SLOPE (SIG_SLOPE)
    ) uLane (
      .clk   (clk),
      .rst   (rst),
      .adv_i (adv),
      .mode_i(mode_q[1]),
      .x_i   (in_data[g*IN_WIDTH +: IN_WIDTH]),
      .y_o   (out_data[g*DATA_WIDTH +: DATA_WIDTH])
    );
  end

endmodule
